// File: rtl/shift_chain_sched.sv
// -----------------------------------------------------------------------------
// shift_chain_sched
//
// Round-robin scheduler that shares one external WIDTH-bit serial shift chain
// between two requesters. It accepts a parallel word from the granted
// requester and shifts it into the chain, one bit per cycle. In the same
// cycles it captures the bits coming back from the chain and, once the
// transfer is complete, presents them as a parallel response word.
//
// Optional build macro:
//   SHIFT_SCHED_LSB_FIRST_EN  - when defined, both the outgoing and returning
//                               bit streams are LSB first. When undefined,
//                               they are MSB first. Timing, handshake and
//                               arbitration are the same in both builds.
//
// Ports:
//   clk                 clock; all state updates on posedge
//   rst                 synchronous active-high reset
//   req0_valid/_data    requester 0 word offer
//   req0_ready          requester 0 word accepted this cycle
//   req1_valid/_data    requester 1 word offer
//   req1_ready          requester 1 word accepted this cycle
//   sh_en               chain shift enable (chain shifts on posedge when 1)
//   sh_out              serial bit driven into the chain
//   sh_in               serial bit returning from the chain
//   resp_valid          one-cycle response pulse, no backpressure
//   resp_data           word captured from sh_in (held until the next response)
//   resp_id             requester that owns the response
//   busy                scheduler is not idle
// -----------------------------------------------------------------------------
module shift_chain_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sh_en,
    output logic             sh_out,
    input  logic             sh_in,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             rr_ptr_reg;
    logic             id_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] resp_data_reg;
    logic             resp_id_reg;

    logic             grant;
    logic             handshake;
    logic             cnt_last;
    logic             tx_bit;
    logic [WIDTH-1:0] tx_shifted;
    logic [WIDTH-1:0] rx_shifted;
    logic [1:0]       req_valid_vec;
    logic [1:0]       req_ready_vec;

    assign req_valid_vec = {req1_valid, req0_valid};

    // With both requesters valid the pointer decides; otherwise the single
    // valid requester wins (grant is only meaningful when one is valid).
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = rr_ptr_reg;
        end
    end

    // Ready is masked while rst is high so nothing is accepted during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_vec[gi] = (state_reg == IDLE) && !rst &&
                                       req_valid_vec[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];
    assign handshake  = |req_ready_vec;
    assign cnt_last   = (cnt_reg == CNT_LAST);

`ifdef SHIFT_SCHED_LSB_FIRST_EN
    assign tx_bit     = tx_reg[0];
    assign tx_shifted = tx_reg >> 1;
    assign rx_shifted = {sh_in, rx_reg[WIDTH-1:1]};
`else
    assign tx_bit     = tx_reg[WIDTH-1];
    assign tx_shifted = tx_reg << 1;
    assign rx_shifted = {rx_reg[WIDTH-2:0], sh_in};
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = SHIFT;
            SHIFT:   if (cnt_last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            id_reg        <= 1'b0;
            cnt_reg       <= '0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            resp_data_reg <= '0;
            resp_id_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        tx_reg     <= grant ? req1_data : req0_data;
                        id_reg     <= grant;
                        rr_ptr_reg <= ~grant;
                        cnt_reg    <= '0;
                        rx_reg     <= '0;
                    end
                end
                SHIFT: begin
                    tx_reg <= tx_shifted;
                    rx_reg <= rx_shifted;
                    if (cnt_last) begin
                        // Latch the completed word on the final shift so the
                        // response stays stable until the next transfer ends.
                        resp_data_reg <= rx_shifted;
                        resp_id_reg   <= id_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sh_en      = (state_reg == SHIFT);
    assign sh_out     = sh_en & tx_bit;
    assign resp_valid = (state_reg == DONE);
    assign resp_data  = resp_data_reg;
    assign resp_id    = resp_id_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_chain_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_chain_sched
//
// Directed bench for shift_chain_sched with WIDTH=32. Inputs are driven and
// outputs sampled just after the falling edge. sh_in is looped back from
// sh_out, or driven from a 32-bit model of the external chain.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_chain_sched;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             sh_en, sh_out, sh_in;
    logic             resp_valid, resp_id, busy;
    logic [WIDTH-1:0] resp_data;

    logic             ext_mode   = 1'b0;
    logic             model_load = 1'b0;
    logic [WIDTH-1:0] model_reg  = '0;
    int               cyc        = 0;
    int               checks     = 0;
    int               errors     = 0;

    shift_chain_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sh_en      (sh_en),
        .sh_out     (sh_out),
        .sh_in      (sh_in),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External chain model: MSB leaves on sh_in, sh_out enters at the LSB.
    always @(posedge clk) begin
        if (model_load)
            model_reg <= 32'hDEAD_BEEF;
        else if (ext_mode && sh_en)
            model_reg <= {model_reg[WIDTH-2:0], sh_out};
    end

    assign sh_in = ext_mode ? model_reg[WIDTH-1] : sh_out;

    // Order in which a word's bits appear on a serial line, collected
    // first-bit-into-MSB: identity for MSB-first, bit reversal for LSB-first.
    function automatic logic [31:0] bit_order(input logic [31:0] d);
        logic [31:0] r;
`ifdef SHIFT_SCHED_LSB_FIRST_EN
        r = {<<{d}};
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offers one word from requester 'who' (currently idle), shifts it and
    // checks the serial stream and the response. Ends in the next idle cycle.
    task automatic xfer(input int who, input logic [31:0] data,
                        input logic [31:0] exp_resp, input string tag);
        logic [31:0] word;
        int          en_cnt;
        int          rdy_cnt;
        word    = '0;
        en_cnt  = 0;
        rdy_cnt = 0;
        if (who == 0) begin req0_valid = 1'b1; req0_data = data; end
        else          begin req1_valid = 1'b1; req1_data = data; end
        #1;
        check_eq({tag, "_ready_own"},   32'(who == 0 ? req0_ready : req1_ready), 32'd1);
        check_eq({tag, "_ready_other"}, 32'(who == 0 ? req1_ready : req0_ready), 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            if (sh_en) begin
                en_cnt++;
                word = {word[30:0], sh_out};
            end
            if (req0_ready || req1_ready) rdy_cnt++;
        end
        check_eq({tag, "_en_cycles"}, 32'(en_cnt), 32'd32);
        check_eq({tag, "_sh_out"},    word, bit_order(data));
        check_eq({tag, "_no_ready"},  32'(rdy_cnt), 32'd0);
        tick();
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, "_resp_data"},  resp_data, exp_resp);
        check_eq({tag, "_resp_id"},    32'(resp_id), 32'(who));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_eq({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_idle"},      32'(busy), 32'd0);
        check_eq({tag, "_hold"},      resp_data, exp_resp);
        $display("xfer %s: req%0d data=0x%08h resp=0x%08h id=%0d", tag, who, data, resp_data, resp_id);
    endtask

    initial begin
        int          found;
        int          prev_hs;
        int          seen;
        logic [31:0] cdata;

        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 32'hA5C3_0F96;
        req1_valid = 1'b0;
        req1_data  = '0;

        // 1: reset held two cycles with req0 offering
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_ready0",     32'(req0_ready), 32'd0);
            check_eq("rst_sh_en",      32'(sh_en),      32'd0);
            check_eq("rst_sh_out",     32'(sh_out),     32'd0);
            check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
            check_eq("rst_busy",       32'(busy),       32'd0);
        end
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_resp_id",   32'(resp_id), 32'd0);
        rst = 1'b0;
        $display("reset: done");

        // 2: single transfer, loopback
        xfer(0, 32'hA5C3_0F96, 32'hA5C3_0F96, "single");

        // Reset while idle; rr_ptr was 1, so contention must start at req0.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 3: contention
        req0_valid = 1'b1; req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_data = 32'h2222_2222;
        #1;
        prev_hs = 0;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int t = 0; t < 40 && found == 0; t++) begin
                if (req0_ready || req1_ready) found = 1;
                else tick();
            end
            check_eq("cont_hs_seen", 32'(found), 32'd1);
            check_eq("cont_grant", 32'(req1_ready), 32'(k % 2));
            check_eq("cont_one_ready", 32'(req0_ready && req1_ready), 32'd0);
            if (k > 0) check_eq("cont_spacing", 32'(cyc - prev_hs), 32'd34);
            prev_hs = cyc;
            found = 0;
            for (int t = 0; t < 40 && found == 0; t++) begin
                tick();
                if (resp_valid) found = 1;
            end
            cdata = (k % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111;
            check_eq("cont_resp_seen", 32'(found), 32'd1);
            check_eq("cont_resp_id",   32'(resp_id), 32'(k % 2));
            check_eq("cont_resp_data", resp_data, cdata);
            $display("contention %0d: id=%0d data=0x%08h", k, resp_id, resp_data);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 4: external chain preloaded with 0xDEADBEEF, send zero
        ext_mode   = 1'b1;
        model_load = 1'b1;
        tick();
        model_load = 1'b0;
        xfer(0, 32'h0000_0000, bit_order(32'hDEAD_BEEF), "chain");
        check_eq("chain_model", model_reg, 32'h0000_0000);
        ext_mode = 1'b0;

        // 5: abort a req1 transfer at shift cycle 10
        req1_valid = 1'b1;
        req1_data  = 32'hC0DE_F00D;
        #1;
        check_eq("abort_ready1", 32'(req1_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            req1_valid = 1'b0;
        end
        check_eq("abort_mid_sh_en", 32'(sh_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_sh_en", 32'(sh_en), 32'd0);
        check_eq("abort_busy",  32'(busy),  32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        check_eq("abort_no_resp", 32'(seen), 32'd0);
        $display("abort: resp pulses after abort=%0d", seen);
        xfer(1, 32'h0F0F_1234, 32'h0F0F_1234, "after_abort");

        // 6: single set bit from req1 (first shift cycle only when LSB first,
        // last shift cycle only when MSB first)
        xfer(1, 32'h0000_0001, 32'h0000_0001, "onebit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
